cond_seq_waiter: RTL and testbench

//   Synthesizable, parametrised sequence-of-conditions waiter. Holds a programmed

---
 rtl/cond_seq_waiter.sv | 189 ++++++++++++++++++
 tb/tb_cond_seq_waiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_seq_waiter.sv
// Sequence-of-conditions waiter: steps through up to NUM_STAGES programmed
// signed compares over a live variable bus, with an optional per-stage timeout.
module cond_seq_waiter #(
  parameter int WIDTH      = 32,
  parameter int NUM_VARS   = 4,
  parameter int NUM_STAGES = 4,
  parameter int TIMEOUT_W  = 16,
  localparam int IDX_W     = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1,
  localparam int STG_W     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
  localparam int NA_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [NUM_VARS*WIDTH-1:0]   vars,
  input  logic [NA_W-1:0]             num_active,
  input  logic [NUM_STAGES*3-1:0]     cfg_op,
  input  logic [NUM_STAGES*IDX_W-1:0] cfg_a,
  input  logic [NUM_STAGES*IDX_W-1:0] cfg_b,
  input  logic [NUM_STAGES*IDX_W-1:0] cfg_c,
  input  logic [TIMEOUT_W-1:0]        timeout,
  output logic                        busy,
  output logic [STG_W-1:0]            stage,
  output logic                        stage_hit,
  output logic                        done,
  output logic                        timed_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2,
    S_TMO  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [STG_W-1:0]      r_stage;
  logic [STG_W-1:0]      w_stage_next;
  logic [TIMEOUT_W-1:0]  r_cnt;
  logic [TIMEOUT_W-1:0]  w_cnt_next;
  logic                  r_hit;
  logic                  w_hit_next;
  logic                  w_load;

  // Configuration shadows, captured only when a sequence is (re)started
  logic [2:0]            r_op [NUM_STAGES];
  logic [IDX_W-1:0]      r_a  [NUM_STAGES];
  logic [IDX_W-1:0]      r_b  [NUM_STAGES];
  logic [IDX_W-1:0]      r_c  [NUM_STAGES];
  logic [NA_W-1:0]       r_num;
  logic [TIMEOUT_W-1:0]  r_timeout;

  logic [NA_W-1:0]       w_num_clamped;
  logic signed [WIDTH-1:0] w_var [NUM_VARS];
  logic signed [WIDTH-1:0] w_opa;
  logic signed [WIDTH-1:0] w_opb;
  logic signed [WIDTH-1:0] w_opc;
  logic signed [WIDTH:0]   w_sum;
  logic signed [WIDTH:0]   w_opc_ext;
  logic                    w_cond;
  logic                    w_last;
  logic                    w_expire;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VARS; gi++) begin : g_unpack
      assign w_var[gi] = vars[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign w_num_clamped = (num_active > NA_W'(NUM_STAGES)) ? NA_W'(NUM_STAGES) : num_active;

  // Operand mux; an index with no matching variable leaves the operand at 0
  always_comb begin
    w_opa = '0;
    w_opb = '0;
    w_opc = '0;
    for (int k = 0; k < NUM_VARS; k++) begin
      if (r_a[r_stage] == IDX_W'(k)) w_opa = w_var[k];
      if (r_b[r_stage] == IDX_W'(k)) w_opb = w_var[k];
      if (r_c[r_stage] == IDX_W'(k)) w_opc = w_var[k];
    end
  end

  assign w_sum     = {w_opa[WIDTH-1], w_opa} + {w_opb[WIDTH-1], w_opb};
  assign w_opc_ext = {w_opc[WIDTH-1], w_opc};

  always_comb begin
    w_cond = 1'b0;
    case (r_op[r_stage])
      3'd0:    w_cond = (w_opa > w_opb);
      3'd1:    w_cond = (w_opa < w_opb);
      3'd2:    w_cond = (w_opa == w_opb);
      3'd3:    w_cond = (w_opa != w_opb);
      3'd4:    w_cond = (w_sum < w_opc_ext);
      3'd5:    w_cond = (w_sum > w_opc_ext);
      3'd6:    w_cond = (w_opa < w_opb) && (w_opb > w_opc);
      default: w_cond = 1'b1;
    endcase
  end

  assign w_last   = (NA_W'(r_stage) == (r_num - NA_W'(1)));
  assign w_expire = (r_timeout != '0) && (r_cnt == (r_timeout - TIMEOUT_W'(1)));

  always_comb begin
    w_state_next = r_state;
    w_stage_next = r_stage;
    w_cnt_next   = r_cnt;
    w_hit_next   = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_load = 1'b1;
      end
      S_WAIT: begin
        if (abort) begin
          w_state_next = S_IDLE;
          w_stage_next = '0;
          w_cnt_next   = '0;
        end else if (w_cond) begin
          // A met condition takes precedence over a simultaneous expiry
          w_hit_next = 1'b1;
          w_cnt_next = '0;
          if (w_last) w_state_next = S_DONE;
          else        w_stage_next = r_stage + STG_W'(1);
        end else if (w_expire) begin
          w_state_next = S_TMO;
        end else begin
          w_cnt_next = r_cnt + TIMEOUT_W'(1);
        end
      end
      default: begin
        if (abort) begin
          w_state_next = S_IDLE;
          w_stage_next = '0;
          w_cnt_next   = '0;
        end else if (start) begin
          w_load = 1'b1;
        end
      end
    endcase
    if (w_load) begin
      w_stage_next = '0;
      w_cnt_next   = '0;
      w_state_next = (w_num_clamped == '0) ? S_DONE : S_WAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_stage   <= '0;
      r_cnt     <= '0;
      r_hit     <= 1'b0;
      r_num     <= '0;
      r_timeout <= '0;
      for (int s = 0; s < NUM_STAGES; s++) begin
        r_op[s] <= '0;
        r_a[s]  <= '0;
        r_b[s]  <= '0;
        r_c[s]  <= '0;
      end
    end else begin
      r_state <= w_state_next;
      r_stage <= w_stage_next;
      r_cnt   <= w_cnt_next;
      r_hit   <= w_hit_next;
      if (w_load) begin
        r_num     <= w_num_clamped;
        r_timeout <= timeout;
        for (int s = 0; s < NUM_STAGES; s++) begin
          r_op[s] <= cfg_op[s*3 +: 3];
          r_a[s]  <= cfg_a[s*IDX_W +: IDX_W];
          r_b[s]  <= cfg_b[s*IDX_W +: IDX_W];
          r_c[s]  <= cfg_c[s*IDX_W +: IDX_W];
        end
      end
    end
  end

  assign busy      = (r_state == S_WAIT);
  assign done      = (r_state == S_DONE);
  assign timed_out = (r_state == S_TMO);
  assign stage     = r_stage;
  assign stage_hit = r_hit;

endmodule

// File: tb/tb_cond_seq_waiter.sv
// Directed bench for cond_seq_waiter: a 32-bit/4-var instance for sequencing
// and timeouts, and an 8-bit/3-var instance for sign, width and index range.
module tb_cond_seq_waiter;

  logic clk;
  logic rst;

  // Main instance: WIDTH=32, NUM_VARS=4, NUM_STAGES=4
  logic         start, abort;
  logic [127:0] vars;
  logic [2:0]   num_active;
  logic [11:0]  cfg_op;
  logic [7:0]   cfg_a, cfg_b, cfg_c;
  logic [15:0]  timeout;
  logic         busy, stage_hit, done, timed_out;
  logic [1:0]   stage;

  // Narrow instance: WIDTH=8, NUM_VARS=3, NUM_STAGES=4
  logic         start8, abort8;
  logic [23:0]  vars8;
  logic [2:0]   num8;
  logic [11:0]  op8;
  logic [7:0]   a8, b8, c8;
  logic [15:0]  tmo8;
  logic         busy8, hit8, done8, tout8;
  logic [1:0]   stage8;

  int n_checks = 0;
  int n_pass   = 0;
  int hits     = 0;
  logic saw_tmo;

  cond_seq_waiter #(.WIDTH(32), .NUM_VARS(4), .NUM_STAGES(4), .TIMEOUT_W(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .vars(vars),
    .num_active(num_active), .cfg_op(cfg_op), .cfg_a(cfg_a), .cfg_b(cfg_b),
    .cfg_c(cfg_c), .timeout(timeout), .busy(busy), .stage(stage),
    .stage_hit(stage_hit), .done(done), .timed_out(timed_out)
  );

  cond_seq_waiter #(.WIDTH(8), .NUM_VARS(3), .NUM_STAGES(4), .TIMEOUT_W(16)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .abort(abort8), .vars(vars8),
    .num_active(num8), .cfg_op(op8), .cfg_a(a8), .cfg_b(b8),
    .cfg_c(c8), .timeout(tmo8), .busy(busy8), .stage(stage8),
    .stage_hit(hit8), .done(done8), .timed_out(tout8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (stage_hit) hits++;
      if (timed_out) saw_tmo = 1'b1;
    end
  endtask

  task automatic set_var(input int k, input logic [31:0] v);
    vars[k*32 +: 32] = v;
  endtask

  task automatic set_stage(input int s, input logic [2:0] op,
                           input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
    cfg_op[s*3 +: 3] = op;
    cfg_a[s*2 +: 2]  = a;
    cfg_b[s*2 +: 2]  = b;
    cfg_c[s*2 +: 2]  = c;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic start_dut8();
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 0; abort = 0; vars = '0; num_active = '0;
    cfg_op = '0; cfg_a = '0; cfg_b = '0; cfg_c = '0; timeout = '0;
    start8 = 0; abort8 = 0; vars8 = '0; num8 = '0;
    op8 = '0; a8 = '0; b8 = '0; c8 = '0; tmo8 = '0;
    saw_tmo = 1'b0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_stage", stage, 0);
    check("rst_hit", stage_hit, 0);
    check("rst_done", done, 0);
    check("rst_tmo", timed_out, 0);
    rst = 1'b0;
    tick();

    // 1: a>b, a+b<c, (a<b)&&(b>c) on a=v0, b=v1, c=v2
    set_stage(0, 3'd0, 2'd0, 2'd1, 2'd2);
    set_stage(1, 3'd4, 2'd0, 2'd1, 2'd2);
    set_stage(2, 3'd6, 2'd0, 2'd1, 2'd2);
    num_active = 3'd3;
    pulse_start();
    check("t1_busy", busy, 1);
    hits = 0; set_var(1, 1); run(4);
    check("t1_b1_hits", hits, 0);  check("t1_b1_stage", stage, 0);
    hits = 0; set_var(0, 2); run(4);
    check("t1_a2_hits", hits, 1);  check("t1_a2_stage", stage, 1);
    hits = 0; set_var(2, 3); run(4);
    check("t1_c3_hits", hits, 0);  check("t1_c3_stage", stage, 1);
    hits = 0; set_var(2, 4); run(4);
    check("t1_c4_hits", hits, 1);  check("t1_c4_stage", stage, 2);
    hits = 0; set_var(1, 5); run(4);
    check("t1_b5_hits", hits, 1);
    check("t1_done", done, 1);
    check("t1_busy_end", busy, 0);
    check("t1_never_tmo", saw_tmo, 0);

    // 2: stage0 always true, stage1 v0>v0 never true, timeout 5
    set_stage(0, 3'd7, 2'd0, 2'd0, 2'd0);
    set_stage(1, 3'd0, 2'd0, 2'd0, 2'd0);
    num_active = 3'd2; timeout = 16'd5;
    pulse_start();
    check("t2_restart_done", done, 0);
    check("t2_wait_stage", stage, 0);
    check("t2_wait_hit", stage_hit, 0);
    tick();
    check("t2_hit", stage_hit, 1);
    check("t2_stage1", stage, 1);
    saw_tmo = 1'b0; run(4);
    check("t2_no_early_tmo", saw_tmo, 0);
    check("t2_busy_pre", busy, 1);
    tick();
    check("t2_tmo", timed_out, 1);
    check("t2_tmo_stage", stage, 1);
    check("t2_tmo_busy", busy, 0);

    // 3: condition met exactly on the expiry cycle
    set_var(0, 0); set_var(1, 7);
    set_stage(0, 3'd2, 2'd0, 2'd1, 2'd0);
    num_active = 3'd1; timeout = 16'd3;
    pulse_start();
    check("t3_tmo_cleared", timed_out, 0);
    tick(); tick();
    check("t3_busy_pre", busy, 1);
    set_var(1, 0);
    tick();
    check("t3_hit", stage_hit, 1);
    check("t3_done", done, 1);
    check("t3_no_tmo", timed_out, 0);

    // 4: reset mid-WAIT at stage 2, then zero-length sequence
    set_stage(0, 3'd7, 2'd0, 2'd0, 2'd0);
    set_stage(1, 3'd7, 2'd0, 2'd0, 2'd0);
    set_stage(2, 3'd0, 2'd0, 2'd0, 2'd0);
    num_active = 3'd3; timeout = 16'd0;
    pulse_start();
    tick(); tick();
    check("t4_stage2", stage, 2);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t4_rst_busy", busy, 0);
    check("t4_rst_stage", stage, 0);
    check("t4_rst_hit", stage_hit, 0);
    check("t4_rst_done", done, 0);
    check("t4_rst_tmo", timed_out, 0);
    num_active = 3'd0;
    pulse_start();
    check("t4_zero_done", done, 1);
    check("t4_zero_hit", stage_hit, 0);
    check("t4_zero_busy", busy, 0);

    // 6a: start held during WAIT must not reload or reset the timeout count
    set_var(0, 0); set_var(1, 1);
    set_stage(0, 3'd2, 2'd0, 2'd1, 2'd0);
    set_stage(1, 3'd7, 2'd0, 2'd0, 2'd0);
    num_active = 3'd2; timeout = 16'd3;
    pulse_start();
    start = 1'b1; tick(); tick(); start = 1'b0;
    check("t6_start_ign_busy", busy, 1);
    tick();
    check("t6_start_ign_tmo", timed_out, 1);
    // 6b: abort on the same edge the condition becomes true
    timeout = 16'd0;
    pulse_start();
    set_var(1, 0); abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_abort_busy", busy, 0);
    check("t6_abort_hit", stage_hit, 0);
    check("t6_abort_stage", stage, 0);
    check("t6_abort_done", done, 0);
    tick();
    check("t6_idle_hold", busy, 0);

    // num_active above NUM_STAGES is clamped
    for (int s = 0; s < 4; s++) set_stage(s, 3'd7, 2'd0, 2'd0, 2'd0);
    num_active = 3'd7;
    pulse_start();
    hits = 0; run(6);
    check("clamp_hits", hits, 4);
    check("clamp_stage", stage, 3);
    check("clamp_done", done, 1);

    // 5: 8-bit instance, A+B>C with 100+100 vs -1 must not wrap
    vars8 = {8'hFF, 8'd100, 8'd100};
    op8[2:0] = 3'd5; a8[1:0] = 2'd0; b8[1:0] = 2'd1; c8[1:0] = 2'd2;
    num8 = 3'd1;
    start_dut8();
    tick();
    check("t5_sum_hit", hit8, 1);
    check("t5_sum_done", done8, 1);
    // -3 > 2 is false under signed compare
    vars8 = {8'd0, 8'd2, 8'hFD};
    op8[2:0] = 3'd0;
    start_dut8();
    tick(); tick();
    check("t5_signed_busy", busy8, 1);
    check("t5_signed_hit", hit8, 0);
    abort8 = 1'b1; tick(); abort8 = 1'b0;
    // index 3 has no variable and reads as 0, so equals v2=0
    vars8 = {8'd0, 8'd6, 8'd5};
    op8[2:0] = 3'd2; a8[1:0] = 2'd3; b8[1:0] = 2'd2;
    start_dut8();
    tick();
    check("t5_oor_hit", hit8, 1);
    check("t5_oor_done", done8, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
